// File: rtl/tile_cfg_pkg.sv
`default_nettype none
// ============================================================================
// tile_cfg_pkg : shared address fields, state encodings and bus width
// Revision: 1.0
// ============================================================================
package tile_cfg_pkg;

   localparam int TILE_LSB = 0;
   localparam int MOD_LSB  = 16;
   localparam int MOD_MSB  = 31;
   localparam int DATA_W   = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_RESP = 2'd1,
      SETTLE    = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/tile_cfg_reg.sv
`default_nettype none
// ============================================================================
// tile_cfg_reg : one shadow/active configuration pair with its dirty bit
// Revision: 1.0
// ============================================================================
module tile_cfg_reg #(
   parameter int CFG_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [CFG_W-1:0] wr_data,
   input  logic             commit,
   output logic [CFG_W-1:0] shadow,
   output logic [CFG_W-1:0] active,
   output logic             dirty
);

   logic [CFG_W-1:0] shadow_q;
   logic [CFG_W-1:0] shadow_d;
   logic [CFG_W-1:0] active_q;
   logic             dirty_q;

   // The commit copy sees a write landing on the same edge.
   assign shadow_d = wr_en ? wr_data : shadow_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= '0;
         active_q <= '0;
         dirty_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         if (commit) begin
            active_q <= shadow_d;
            dirty_q  <= 1'b0;
         end else if (wr_en) begin
            dirty_q  <= 1'b1;
         end
      end
   end

   assign shadow = shadow_q;
   assign active = active_q;
   assign dirty  = dirty_q;

endmodule
`default_nettype wire

// File: rtl/tile_config_unit.sv
`default_nettype none
// ============================================================================
// tile_config_unit : PE tile config decoder, shadow/active bank, commit/settle
// Revision: 1.0
// ============================================================================
module tile_config_unit
   import tile_cfg_pkg::*;
#(
   parameter int NUM_MODS      = 4,
   parameter int MOD_BASE      = 16,
   parameter int CFG_W         = 8,
   parameter int SETTLE_CYCLES = 3,
   parameter int TILE_ID_W     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [TILE_ID_W-1:0]      tile_id,
   input  logic                      config_valid,
   output logic                      config_ready,
   input  logic                      config_we,
   input  logic [31:0]               config_addr,
   input  logic [31:0]               config_data,
   input  logic                      config_commit,
   output logic                      config_rvalid,
   output logic [31:0]               config_rdata,
   output logic                      config_err,
   output logic [NUM_MODS-1:0]       cfg_dirty,
   output logic [NUM_MODS*CFG_W-1:0] cfg_active,
   output logic                      cfg_busy
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pending_q, pending_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [NUM_MODS-1:0] wr_en;
   logic                commit_now;
   logic [CFG_W-1:0]    shadow [NUM_MODS];
   logic [CFG_W-1:0]    rd_val;
   logic                tile_hit;
   logic [15:0]         mod_id;
   logic [15:0]         mod_off;
   logic                mod_ok;
   logic                accept;
   logic                w_unused_bits;

   assign w_unused_bits = ^{config_addr, config_data};

   assign tile_hit = (config_addr[TILE_LSB +: TILE_ID_W] == tile_id);
   assign mod_id   = config_addr[MOD_MSB:MOD_LSB];
   assign mod_off  = mod_id - 16'(MOD_BASE);
   assign mod_ok   = (mod_id >= 16'(MOD_BASE)) && (mod_off < 16'(NUM_MODS));
   assign accept   = config_valid & config_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pending_d  = pending_q;
      rvalid_d   = 1'b0;
      rdata_d    = '0;
      err_d      = 1'b0;
      wr_en      = '0;
      commit_now = 1'b0;
      rd_val     = '0;

      for (int i = 0; i < NUM_MODS; i++) begin
         if (mod_off == 16'(i)) rd_val = shadow[i];
      end

      case (state_q)
         IDLE: begin
            commit_now = config_commit | pending_q;
            pending_d  = 1'b0;
            if (accept && tile_hit) begin
               if (!mod_ok) begin
                  err_d = 1'b1;
               end else if (config_we) begin
                  for (int i = 0; i < NUM_MODS; i++) begin
                     wr_en[i] = (mod_off == 16'(i));
                  end
               end else begin
                  rvalid_d = 1'b1;
                  rdata_d  = DATA_W'(rd_val);
                  state_d  = READ_RESP;
               end
            end
            // A read that coincides with a commit still responds next cycle;
            // the settle window also covers the response slot.
            if (commit_now && (SETTLE_CYCLES > 0)) begin
               state_d = SETTLE;
               cnt_d   = SETTLE_LOAD;
            end
         end
         READ_RESP: begin
            state_d = IDLE;
            if (config_commit) pending_d = 1'b1;
         end
         SETTLE: begin
            if (config_commit) pending_d = 1'b1;
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   generate
      for (genvar k = 0; k < NUM_MODS; k++) begin : g_mod
         tile_cfg_reg #(
            .CFG_W (CFG_W)
         ) u_reg (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[k]),
            .wr_data (config_data[CFG_W-1:0]),
            .commit  (commit_now),
            .shadow  (shadow[k]),
            .active  (cfg_active[k*CFG_W +: CFG_W]),
            .dirty   (cfg_dirty[k])
         );
      end
   endgenerate

   assign config_ready  = (state_q == IDLE) & ~reset;
   assign cfg_busy      = (state_q == SETTLE);
   assign config_rvalid = rvalid_q;
   assign config_rdata  = rdata_q;
   assign config_err    = err_q;

endmodule
`default_nettype wire
